// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Holds the state enum, datapath select encodings, opcode/funct values and decode classes.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // ALU op codes (zero-extended to ALUOP_W at the top)
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_ADDV = 3'b100;
  localparam logic [2:0] ALU_SGN  = 3'b101;
  localparam logic [2:0] ALU_ZERO = 3'b111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_RA  = 2'd2;
  localparam logic [1:0] RD_R30 = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_ONE = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BGEZAL = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Bit positions in the instruction-class one-hot
  localparam int C_ADDU   = 0;
  localparam int C_SUBU   = 1;
  localparam int C_SLT    = 2;
  localparam int C_JR     = 3;
  localparam int C_ORI    = 4;
  localparam int C_LW     = 5;
  localparam int C_SW     = 6;
  localparam int C_BEQ    = 7;
  localparam int C_LUI    = 8;
  localparam int C_J      = 9;
  localparam int C_ADDI   = 10;
  localparam int C_ADDIU  = 11;
  localparam int C_JAL    = 12;
  localparam int C_BGEZAL = 13;
  localparam int CLS_N    = 14;

  typedef logic [CLS_N-1:0] cls_t;

endpackage

// File: rtl/mc_controller_if.sv
// Shared instruction/data memory port handshake: the controller raises mem_req
// (with iord/mem_we) and holds it until the memory answers with mem_ready.
interface mc_controller_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to a class one-hot plus legal flag.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       legal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls[C_ADDU] = 1'b1;
          FN_SUBU: cls[C_SUBU] = 1'b1;
          FN_SLT:  cls[C_SLT]  = 1'b1;
          FN_JR:   cls[C_JR]   = 1'b1;
          default: ;
        endcase
      end
      OP_BGEZAL: cls[C_BGEZAL] = 1'b1;
      OP_J:      cls[C_J]      = 1'b1;
      OP_JAL:    cls[C_JAL]    = 1'b1;
      OP_BEQ:    cls[C_BEQ]    = 1'b1;
      OP_ADDI:   cls[C_ADDI]   = 1'b1;
      OP_ADDIU:  cls[C_ADDIU]  = 1'b1;
      OP_ORI:    cls[C_ORI]    = 1'b1;
      OP_LUI:    cls[C_LUI]    = 1'b1;
      OP_LW:     cls[C_LW]     = 1'b1;
      OP_SW:     cls[C_SW]     = 1'b1;
      default: ;
    endcase
  end

  assign legal = |cls;

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving datapath enables and selects.
// Optional MC_OVF_GPR30_EN: addi traps signed overflow by writing 1 to $30 instead of rt.
module mc_controller
  import mc_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               sign,
  input  logic               overflow,
  mc_controller_if.master    mem_bus,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               alu_src_b,
  output logic [1:0]         ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [2:0]         state
);

  state_t state_q;
  cls_t   cls;
  logic   legal;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls),
    .legal  (legal)
  );

  logic is_rtype;
  assign is_rtype = cls[C_ADDU] | cls[C_SUBU] | cls[C_SLT];

`ifdef MC_OVF_GPR30_EN
  logic ovf_q;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
`ifdef MC_OVF_GPR30_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_FETCH: begin
`ifdef MC_OVF_GPR30_EN
          ovf_q <= 1'b0;
`endif
          if (mem_bus.mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (!legal || cls[C_J] || cls[C_JAL] || cls[C_JR]) state_q <= S_FETCH;
          else                                                  state_q <= S_EXEC;
        end
        S_EXEC: begin
`ifdef MC_OVF_GPR30_EN
          ovf_q <= overflow & cls[C_ADDI];
`endif
          if (cls[C_LW] || cls[C_SW])          state_q <= S_MEM;
          else if (cls[C_BEQ] || cls[C_BGEZAL]) state_q <= S_FETCH;
          else                                  state_q <= S_WB;
        end
        S_MEM: begin
          if (mem_bus.mem_ready) state_q <= cls[C_SW] ? S_FETCH : S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  logic       c_mem_req, c_mem_we, c_iord, c_ir_we, c_pc_we, c_reg_we;
  logic       c_alu_src_b, c_illegal;
  logic [1:0] c_pc_src, c_reg_dst, c_wb_sel, c_ext_op;
  logic [2:0] c_alu_op;

  always_comb begin
    c_mem_req   = 1'b0;
    c_mem_we    = 1'b0;
    c_iord      = 1'b0;
    c_ir_we     = 1'b0;
    c_pc_we     = 1'b0;
    c_pc_src    = PC_PLUS4;
    c_reg_we    = 1'b0;
    c_reg_dst   = RD_RT;
    c_wb_sel    = WB_ALU;
    c_alu_src_b = 1'b0;
    c_ext_op    = EXT_ZERO;
    c_alu_op    = ALU_ADD;
    c_illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        c_mem_req = 1'b1;
        c_ir_we   = mem_bus.mem_ready;
        c_pc_we   = mem_bus.mem_ready;
      end
      S_DECODE: begin
        c_illegal = ~legal;
        if (cls[C_J] || cls[C_JAL]) begin
          c_pc_we  = 1'b1;
          c_pc_src = PC_JUMP;
        end
        if (cls[C_JAL]) begin
          c_reg_we  = 1'b1;
          c_reg_dst = RD_RA;
          c_wb_sel  = WB_PC4;
        end
        if (cls[C_JR]) begin
          c_pc_we  = 1'b1;
          c_pc_src = PC_RS;
        end
      end
      S_EXEC: begin
        if (cls[C_SUBU] || cls[C_BEQ]) c_alu_op = ALU_SUB;
        if (cls[C_SLT])                c_alu_op = ALU_SLT;
        if (cls[C_ORI])                c_alu_op = ALU_OR;
        if (cls[C_BGEZAL])             c_alu_op = ALU_SGN;
`ifdef MC_OVF_GPR30_EN
        if (cls[C_ADDI])               c_alu_op = ALU_ADDV;
`endif
        c_alu_src_b = cls[C_ORI] | cls[C_LW] | cls[C_SW] | cls[C_LUI] |
                      cls[C_ADDI] | cls[C_ADDIU];
        if (cls[C_LW] || cls[C_SW] || cls[C_ADDI] || cls[C_ADDIU]) c_ext_op = EXT_SIGN;
        if (cls[C_LUI])                                             c_ext_op = EXT_LUI;
        // Branch controls only assert when the branch is actually taken
        if (cls[C_BEQ] && zero) begin
          c_pc_we  = 1'b1;
          c_pc_src = PC_BRANCH;
        end
        if (cls[C_BGEZAL] && !sign) begin
          c_pc_we   = 1'b1;
          c_pc_src  = PC_BRANCH;
          c_reg_we  = 1'b1;
          c_reg_dst = RD_RA;
          c_wb_sel  = WB_PC4;
        end
      end
      S_MEM: begin
        c_mem_req = 1'b1;
        c_iord    = 1'b1;
        c_mem_we  = cls[C_SW];
      end
      S_WB: begin
        c_reg_we  = 1'b1;
        c_reg_dst = is_rtype ? RD_RD : RD_RT;
        c_wb_sel  = cls[C_LW] ? WB_MDR : WB_ALU;
`ifdef MC_OVF_GPR30_EN
        if (ovf_q) begin
          c_reg_dst = RD_R30;
          c_wb_sel  = WB_ONE;
        end
`endif
      end
      default: ;
    endcase
  end

  // Outputs are forced to zero for as long as reset is held
  assign mem_bus.mem_req = rst_n & c_mem_req;
  assign mem_bus.mem_we  = rst_n & c_mem_we;
  assign mem_bus.iord    = rst_n & c_iord;
  assign ir_we     = rst_n & c_ir_we;
  assign pc_we     = rst_n & c_pc_we;
  assign pc_src    = rst_n ? c_pc_src  : 2'd0;
  assign reg_we    = rst_n & c_reg_we;
  assign reg_dst   = rst_n ? c_reg_dst : 2'd0;
  assign wb_sel    = rst_n ? c_wb_sel  : 2'd0;
  assign alu_src_b = rst_n & c_alu_src_b;
  assign ext_op    = rst_n ? c_ext_op  : 2'd0;
  assign alu_op    = rst_n ? ALUOP_W'(c_alu_op) : '0;
  assign illegal   = rst_n & c_illegal;
  assign state     = rst_n ? state_q : S_FETCH;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: per-instruction cycle model feeding an expected-output queue.
// Honours MC_OVF_GPR30_EN the same way as the design.
module tb_mc_controller;

  localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ORI = 4, K_LW = 5, K_SW = 6;
  localparam int K_BEQ = 7, K_LUI = 8, K_J = 9, K_ADDI = 10, K_ADDIU = 11, K_JAL = 12;
  localparam int K_BGEZAL = 13, K_ILL = 14;

  typedef struct packed {
    logic [2:0] st;
    logic       ill;
    logic [2:0] aop;
    logic [1:0] ext;
    logic       asb;
    logic [1:0] wbs;
    logic [1:0] rdst;
    logic       rwe;
    logic [1:0] psrc;
    logic       pwe;
    logic       irwe;
    logic       iord;
    logic       mwe;
    logic       mreq;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, sign = 1'b0, overflow = 1'b0;
  logic       ir_we, pc_we, reg_we, alu_src_b, illegal;
  logic [1:0] pc_src, reg_dst, wb_sel, ext_op;
  logic [2:0] alu_op, state;

  mc_controller_if mif ();

  mc_controller #(.ALUOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .sign(sign), .overflow(overflow), .mem_bus(mif),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  outs_t act;
  assign act = '{st: state, ill: illegal, aop: alu_op, ext: ext_op, asb: alu_src_b,
                 wbs: wb_sel, rdst: reg_dst, rwe: reg_we, psrc: pc_src, pwe: pc_we,
                 irwe: ir_we, iord: mif.iord, mwe: mif.mem_we, mreq: mif.mem_req};

  // scoreboard
  logic [21:0] exp_q[$];
  outs_t       trace[$];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        logic [21:0] ex;
        ex = exp_q.pop_front();
        check("cycle_outputs", 32'(act), 32'(ex));
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) return fn inside {6'b100001, 6'b100011, 6'b101010, 6'b001000};
    return op inside {6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b001111,
                      6'b000010, 6'b001000, 6'b001001, 6'b000011, 6'b000001};
  endfunction

  function automatic void encode(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    op = 6'd0;
    case (k)
      K_ADDU:   fn = 6'b100001;
      K_SUBU:   fn = 6'b100011;
      K_SLT:    fn = 6'b101010;
      K_JR:     fn = 6'b001000;
      K_ORI:    op = 6'b001101;
      K_LW:     op = 6'b100011;
      K_SW:     op = 6'b101011;
      K_BEQ:    op = 6'b000100;
      K_LUI:    op = 6'b001111;
      K_J:      op = 6'b000010;
      K_ADDI:   op = 6'b001000;
      K_ADDIU:  op = 6'b001001;
      K_JAL:    op = 6'b000011;
      K_BGEZAL: op = 6'b000001;
      default: begin
        for (int t = 0; t < 200; t++) begin
          if (rb()) op = 6'd0; else op = 6'($urandom);
          fn = 6'($urandom);
          if (!is_legal(op, fn)) break;
        end
        if (is_legal(op, fn)) begin op = 6'b111111; fn = 6'd0; end
      end
    endcase
  endfunction

  // driver: one clock cycle of stimulus plus the outputs that cycle must show
  task automatic step(input outs_t e, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic s, input logic o, input logic mr);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; zero = z; sign = s; overflow = o; mif.mem_ready = mr;
    exp_q.push_back(22'(e));
    trace.push_back(e);
  endtask

  // instruction-level model: emits the whole cycle-by-cycle output sequence
  task automatic run_instr(input int k, input logic z, input logic s, input logic o,
                           input int fw, input int mw, input bit abort_in_mem);
    outs_t e;
    logic [5:0] op, fn;
    encode(k, op, fn);
    trace.delete();
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mreq = 1'b1;
      step(e, 6'($urandom), 6'($urandom), rb(), rb(), rb(), 1'b0);
    end
    e = '0; e.mreq = 1'b1; e.irwe = 1'b1; e.pwe = 1'b1;
    step(e, 6'($urandom), 6'($urandom), rb(), rb(), rb(), 1'b1);

    e = '0; e.st = 3'd1;
    if (k == K_ILL) e.ill = 1'b1;
    if (k == K_J || k == K_JAL) begin e.pwe = 1'b1; e.psrc = 2'd2; end
    if (k == K_JAL) begin e.rwe = 1'b1; e.rdst = 2'd2; e.wbs = 2'd2; end
    if (k == K_JR) begin e.pwe = 1'b1; e.psrc = 2'd3; end
    step(e, op, fn, rb(), rb(), rb(), rb());
    if (k inside {K_ILL, K_J, K_JAL, K_JR}) return;

    e = '0; e.st = 3'd2;
    case (k)
      K_SUBU, K_BEQ: e.aop = 3'b001;
      K_SLT:         e.aop = 3'b011;
      K_ORI:         e.aop = 3'b010;
      K_BGEZAL:      e.aop = 3'b101;
      default:       e.aop = 3'b000;
    endcase
`ifdef MC_OVF_GPR30_EN
    if (k == K_ADDI) e.aop = 3'b100;
`endif
    e.asb = (k inside {K_ORI, K_LW, K_SW, K_LUI, K_ADDI, K_ADDIU});
    if (k inside {K_LW, K_SW, K_ADDI, K_ADDIU}) e.ext = 2'b01;
    if (k == K_LUI) e.ext = 2'b10;
    if (k == K_BEQ && z) begin e.pwe = 1'b1; e.psrc = 2'd1; end
    if (k == K_BGEZAL && !s) begin
      e.pwe = 1'b1; e.psrc = 2'd1; e.rwe = 1'b1; e.rdst = 2'd2; e.wbs = 2'd2;
    end
    step(e, op, fn, z, s, o, rb());
    if (k == K_BEQ || k == K_BGEZAL) return;

    if (k == K_LW || k == K_SW) begin
      e = '0; e.st = 3'd3; e.mreq = 1'b1; e.iord = 1'b1; e.mwe = (k == K_SW);
      for (int i = 0; i < mw; i++) begin
        step(e, op, fn, rb(), rb(), rb(), 1'b0);
        if (abort_in_mem) return;
      end
      step(e, op, fn, rb(), rb(), rb(), 1'b1);
      if (k == K_SW) return;
    end

    e = '0; e.st = 3'd4; e.rwe = 1'b1;
    e.rdst = (k inside {K_ADDU, K_SUBU, K_SLT}) ? 2'd1 : 2'd0;
    e.wbs  = (k == K_LW) ? 2'd1 : 2'd0;
`ifdef MC_OVF_GPR30_EN
    if (k == K_ADDI && o) begin e.rdst = 2'd3; e.wbs = 2'd3; end
`endif
    step(e, op, fn, rb(), rb(), rb(), rb());
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int irq;
    mif.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_all_zero", 32'(act), 32'd0);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_fetch_req", 32'(act), 32'h1);

    // zero-wait addu: 4 cycles, states 0,1,2,4
    run_instr(K_ADDU, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    drain();
    check("addu_cycles", 32'(trace.size()), 32'd4);
    check("addu_states", {trace[0].st, trace[1].st, trace[2].st, trace[3].st}, {3'd0, 3'd1, 3'd2, 3'd4});
    check("addu_wb", {trace[3].rwe, trace[3].rdst, trace[3].wbs, trace[2].aop}, {1'b1, 2'd1, 2'd0, 3'd0});

    // lw with 2 fetch waits and 3 mem waits
    run_instr(K_LW, 1'b0, 1'b0, 1'b0, 2, 3, 1'b0);
    drain();
    check("lw_cycles", 32'(trace.size()), 32'd10);
    irq = 0;
    foreach (trace[i]) irq += int'(trace[i].irwe);
    check("lw_ir_we_once", 32'(irq), 32'd1);
    check("lw_wb_sel", 32'(trace[9].wbs), 32'd1);

    run_instr(K_BEQ, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    drain();
    check("beq_taken", {29'd0, trace[2].pwe, trace[2].psrc}, 32'b1_01);
    check("beq_taken_cycles", 32'(trace.size()), 32'd3);
    run_instr(K_BEQ, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    drain();
    check("beq_not_taken", {29'd0, trace[2].pwe, trace[2].psrc}, 32'd0);

    run_instr(K_JAL, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    drain();
    check("jal_link", {trace[1].rwe, trace[1].rdst, trace[1].wbs}, {1'b1, 2'd2, 2'd2});
    run_instr(K_BGEZAL, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    drain();
    check("bgezal_taken", {trace[2].rwe, trace[2].rdst, trace[2].wbs, trace[2].pwe}, {1'b1, 2'd2, 2'd2, 1'b1});
    run_instr(K_BGEZAL, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    drain();
    check("bgezal_not_taken", {trace[2].rwe, trace[2].pwe}, 2'b00);

    run_instr(K_ILL, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    drain();
    check("illegal_pulse", {trace[1].ill, trace[1].rwe, trace[1].mwe, 29'(trace.size())}, {1'b1, 1'b0, 1'b0, 29'd2});

    run_instr(K_ADDI, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    drain();
`ifdef MC_OVF_GPR30_EN
    check("addi_ovf_wb", {trace[3].rdst, trace[3].wbs, trace[2].aop}, {2'd3, 2'd3, 3'd4});
`else
    check("addi_ovf_wb", {trace[3].rdst, trace[3].wbs, trace[2].aop}, {2'd0, 2'd0, 3'd0});
`endif

    // reset dropped while sw waits in MEM
    run_instr(K_SW, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_sw", 32'(act), 32'd0);
    mif.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("reset_held", 32'(act), 32'd0);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("refetch_after_reset", 32'(act), 32'h1);

    for (int n = 0; n < 300; n++) begin
      run_instr($urandom_range(0, 14), rb(), rb(), rb(),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'b0);
    end
    drain();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
